// File: rtl/fe_mul_arbiter.sv
// fe_mul_arbiter: round-robin sharing of one fe_mulx multiplier among NREQ requesters
module fe_mul_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 320,
    parameter int GW    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_op_a,
    input  logic [NREQ*WIDTH-1:0] req_op_b,
    output logic [NREQ-1:0]       done,
    output logic [WIDTH-1:0]      res,
    output logic                  busy,
    output logic [GW-1:0]         gnt,
    output logic [WIDTH-1:0]      mul_op_a,
    output logic [WIDTH-1:0]      mul_op_b,
    output logic                  mul_valid,
    input  logic [WIDTH-1:0]      mul_res,
    input  logic                  mul_done
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state;
    logic [GW-1:0] ptr, win, nxt;
    // lowest set index at or above ptr wins; otherwise wrap to the lowest set index
    always_comb begin
        win = ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req_valid[i]) win = GW'(i);
        for (int i = NREQ - 1; i >= 0; i--)
            if (req_valid[i] && GW'(i) >= ptr) win = GW'(i);
    end
    assign nxt = (gnt == GW'(NREQ - 1)) ? '0 : gnt + GW'(1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            busy      <= 1'b0;
            done      <= '0;
            res       <= '0;
            mul_op_a  <= '0;
            mul_op_b  <= '0;
            mul_valid <= 1'b0;
        end else begin
            mul_valid <= 1'b0;
            done      <= '0;
            case (state)
                IDLE: if (|req_valid) begin
                    gnt       <= win;
                    mul_op_a  <= req_op_a[win*WIDTH +: WIDTH];
                    mul_op_b  <= req_op_b[win*WIDTH +: WIDTH];
                    mul_valid <= 1'b1;
                    busy      <= 1'b1;
                    state     <= ISSUE;
                end
                ISSUE: state <= WAIT;
                WAIT: if (mul_done) begin
                    res   <= mul_res;
                    done  <= NREQ'(1) << gnt;
                    state <= RESP;
                end
                RESP: begin
                    ptr   <= nxt;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
